crc_check: RTL and testbench

- Receive-side counterpart of the Ethernet CRC-32 generator. Accumulates CRC over a streamed frame, including its trailing 4-byte FCS, and flags pass or fail at end of frame.
- Sits after the MAC receive datapath, in parallel with the payload FIFO. It consumes beats and never back-pressures.
- Supports 8-bit and 64-bit datapaths. The 64-bit path allows a partial final beat.

---
 rtl/crc_check.sv | 137 +++++++++++++
 tb/tb_crc_check.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_check.sv
// crc_check: receive-side Ethernet CRC-32 checker for 8- or 64-bit datapaths.
// Optional macro CRC_CHECK_STATS_EN adds saturating good/bad/abort frame counters.
module crc_check #(
    parameter int DW = 8,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid_in,
    input  logic [DW-1:0] data_in,
    input  logic          last_in,
    input  logic [2:0]    nbytes_in,
    input  logic          abort_in,
    output logic          done_out,
    output logic          crc_ok_out,
    output logic          runt_out,
    output logic [CW-1:0] crc_out,
    output logic          busy_out
`ifdef CRC_CHECK_STATS_EN
    ,
    output logic [15:0]   stat_good_out,
    output logic [15:0]   stat_bad_out,
    output logic [15:0]   stat_abort_out
`endif
);
    localparam int          NB      = DW / 8;
    localparam logic [31:0] POLY    = 32'hEDB88320;
    localparam logic [31:0] INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    if (!((DW == 8 || DW == 64) && CW == 32)) begin : g_bad_param
        $error("crc_check: DW must be 8 or 64 and CW must be 32");
    end

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t r_state, w_state_nxt;

    logic [31:0] r_acc, w_acc_nxt, r_crc;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [16:0] w_cnt_sum;
    logic [3:0]  w_nfold;
    logic        r_done, r_ok, r_runt;
    logic        w_eof, w_abort_drop;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] t;
        t = c ^ {24'd0, b};
        for (int k = 0; k < 8; k++)
            t = t[0] ? ((t >> 1) ^ POLY) : (t >> 1);
        return t;
    endfunction

    // Chained byte steps; a partial last beat folds only its leading bytes.
    always_comb begin
        w_acc_nxt = r_acc;
        w_nfold   = '0;
        for (int i = 0; i < NB; i++) begin
            if (!last_in || nbytes_in == 3'd0 || i < int'(nbytes_in)) begin
                w_acc_nxt = crc_byte(w_acc_nxt, data_in[8*i +: 8]);
                w_nfold   = w_nfold + 4'd1;
            end
        end
        w_cnt_sum = {1'b0, r_cnt} + {13'd0, w_nfold};
        w_cnt_nxt = w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_eof        = 1'b0;
        w_abort_drop = 1'b0;
        if (abort_in) begin
            w_state_nxt  = IDLE;
            w_abort_drop = (r_state == ACTIVE) || (valid_in && last_in);
        end else if (valid_in) begin
            w_state_nxt = last_in ? IDLE : ACTIVE;
            w_eof       = last_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc  <= INIT;
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_ok   <= 1'b0;
            r_runt <= 1'b0;
            r_crc  <= INIT;
        end else begin
            r_done <= w_eof;
            if (abort_in || w_eof) begin
                r_acc <= INIT;
                r_cnt <= '0;
            end else if (valid_in) begin
                r_acc <= w_acc_nxt;
                r_cnt <= w_cnt_nxt;
            end
            // Result registers hold until the next frame completes.
            if (w_eof) begin
                r_crc  <= w_acc_nxt;
                r_runt <= (w_cnt_nxt < 16'd4);
                r_ok   <= (w_acc_nxt == RESIDUE) && (w_cnt_nxt >= 16'd4);
            end
        end
    end

    assign done_out   = r_done;
    assign crc_ok_out = r_ok;
    assign runt_out   = r_runt;
    assign crc_out    = r_crc;
    assign busy_out   = (r_state == ACTIVE);

`ifdef CRC_CHECK_STATS_EN
    logic [15:0] r_good, r_bad, r_abort;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_good  <= '0;
            r_bad   <= '0;
            r_abort <= '0;
        end else begin
            if (r_done && r_ok && r_good != 16'hFFFF)    r_good  <= r_good + 16'd1;
            if (r_done && !r_ok && r_bad != 16'hFFFF)    r_bad   <= r_bad + 16'd1;
            if (w_abort_drop && r_abort != 16'hFFFF)     r_abort <= r_abort + 16'd1;
        end
    end

    assign stat_good_out  = r_good;
    assign stat_bad_out   = r_bad;
    assign stat_abort_out = r_abort;
`endif

endmodule

// File: tb/tb_crc_check.sv
// Scoreboard bench for crc_check: one DW=8 and one DW=64 instance, directed plus random frames.
module tb_crc_check;
    typedef logic [7:0] bq_t[$];
    typedef struct packed { logic ok; logic runt; logic [31:0] crc; } exp_t;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        v8 = 1'b0, l8 = 1'b0, a8 = 1'b0;
    logic [7:0]  d8 = '0;
    logic [2:0]  n8 = '0;
    logic        dn8, ok8, rt8, bz8;
    logic [31:0] c8;
    logic        v64 = 1'b0, l64 = 1'b0, a64 = 1'b0;
    logic [63:0] d64 = '0;
    logic [2:0]  n64 = '0;
    logic        dn64, ok64, rt64, bz64;
    logic [31:0] c64;
`ifdef CRC_CHECK_STATS_EN
    logic [15:0] sg8, sb8, sa8, sg64, sb64, sa64;
`endif

    int vectors = 0, miscompares = 0;
    exp_t q8[$], q64[$];
    int dones8 = 0, dones64 = 0;
    int eg8 = 0, eb8 = 0, ea8 = 0, eg64 = 0, eb64 = 0, ea64 = 0;

    crc_check #(.DW(8)) u_dut8 (
        .clk(clk), .reset(reset), .valid_in(v8), .data_in(d8), .last_in(l8),
        .nbytes_in(n8), .abort_in(a8), .done_out(dn8), .crc_ok_out(ok8),
        .runt_out(rt8), .crc_out(c8), .busy_out(bz8)
`ifdef CRC_CHECK_STATS_EN
        , .stat_good_out(sg8), .stat_bad_out(sb8), .stat_abort_out(sa8)
`endif
    );

    crc_check #(.DW(64)) u_dut64 (
        .clk(clk), .reset(reset), .valid_in(v64), .data_in(d64), .last_in(l64),
        .nbytes_in(n64), .abort_in(a64), .done_out(dn64), .crc_ok_out(ok64),
        .runt_out(rt64), .crc_out(c64), .busy_out(bz64)
`ifdef CRC_CHECK_STATS_EN
        , .stat_good_out(sg64), .stat_bad_out(sb64), .stat_abort_out(sa64)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: bit-serial reflected CRC over the whole byte list.
    function automatic logic [31:0] model_crc(input bq_t b);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (b[i])
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[i][k];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        return c;
    endfunction

    function automatic exp_t model(input bq_t b);
        exp_t e;
        e.crc  = model_crc(b);
        e.runt = (b.size() < 4);
        e.ok   = (e.crc == RESIDUE) && !e.runt;
        return e;
    endfunction

    function automatic bq_t good_frame(input int len);
        bq_t p;
        logic [31:0] fcs;
        for (int i = 0; i < len; i++) p.push_back(8'($urandom));
        fcs = ~model_crc(p);
        for (int i = 0; i < 4; i++) p.push_back(fcs[8*i +: 8]);
        return p;
    endfunction

    function automatic bq_t gen_frame(input int kind);
        bq_t p;
        int  idx;
        if (kind == 7) begin
            for (int i = 0; i < $urandom_range(1, 3); i++) p.push_back(8'($urandom));
        end else begin
            p = good_frame($urandom_range(1, 30));
            if (kind == 5 || kind == 6) begin
                idx    = $urandom_range(0, p.size() - 1);
                p[idx] = p[idx] ^ 8'(1 << $urandom_range(0, 7));
            end
        end
        return p;
    endfunction

    task automatic expect8(input exp_t e);
        q8.push_back(e);
        if (e.ok) eg8++; else eb8++;
    endtask

    task automatic expect64(input exp_t e);
        q64.push_back(e);
        if (e.ok) eg64++; else eb64++;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            v8 = 1'b0; a8 = 1'b0; l8 = 1'($urandom); d8 = 8'($urandom);
            v64 = 1'b0; a64 = 1'b0; l64 = 1'($urandom); d64 = {$urandom, $urandom};
        end
    endtask

    task automatic send8(input bq_t b, input int abort_at, input bit gaps);
        for (int i = 0; i < b.size(); i++) begin
            if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
                cyc(); v8 = 1'b0; a8 = 1'b0; l8 = 1'($urandom);
            end
            cyc();
            v64 = 1'b0; a64 = 1'b0;
            v8 = 1'b1; d8 = b[i]; l8 = (i == b.size() - 1); n8 = 3'($urandom);
            a8 = (i == abort_at);
            if (i == 1) check("dut8 busy_out mid-frame", 32'(bz8), 32'd1);
            if (i == abort_at) begin
                if (i > 0 || l8) ea8++;
                break;
            end
        end
    endtask

    task automatic send64(input bq_t b, input int abort_at, input bit gaps);
        int nb, nbeats;
        logic [63:0] w;
        nb = b.size();
        nbeats = (nb + 7) / 8;
        for (int bt = 0; bt < nbeats; bt++) begin
            w = {$urandom, $urandom};
            for (int k = 0; k < 8; k++)
                if (bt*8 + k < nb) w[8*k +: 8] = b[bt*8 + k];
            if (gaps && bt > 0 && $urandom_range(0, 3) == 0) begin
                cyc(); v64 = 1'b0; a64 = 1'b0; l64 = 1'($urandom);
            end
            cyc();
            v8 = 1'b0; a8 = 1'b0;
            v64 = 1'b1; d64 = w; l64 = (bt == nbeats - 1);
            n64 = l64 ? 3'(nb % 8) : 3'($urandom);
            a64 = (bt == abort_at);
            if (bt == 1) check("dut64 busy_out mid-frame", 32'(bz64), 32'd1);
            if (bt == abort_at) begin
                if (bt > 0 || l64) ea64++;
                break;
            end
        end
    endtask

    task automatic check_stats();
`ifdef CRC_CHECK_STATS_EN
        check("dut8 stat_good_out", 32'(sg8), 32'(eg8));
        check("dut8 stat_bad_out", 32'(sb8), 32'(eb8));
        check("dut8 stat_abort_out", 32'(sa8), 32'(ea8));
        check("dut64 stat_good_out", 32'(sg64), 32'(eg64));
        check("dut64 stat_bad_out", 32'(sb64), 32'(eb64));
        check("dut64 stat_abort_out", 32'(sa64), 32'(ea64));
`endif
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && dn8 === 1'b1) begin
            dones8++;
            if (q8.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL dut8 done_out: got a pulse, expected none pending");
            end else begin
                e = q8.pop_front();
                check("dut8 crc_out", c8, e.crc);
                check("dut8 crc_ok_out", 32'(ok8), 32'(e.ok));
                check("dut8 runt_out", 32'(rt8), 32'(e.runt));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && dn64 === 1'b1) begin
            dones64++;
            if (q64.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL dut64 done_out: got a pulse, expected none pending");
            end else begin
                e = q64.pop_front();
                check("dut64 crc_out", c64, e.crc);
                check("dut64 crc_ok_out", 32'(ok64), 32'(e.ok));
                check("dut64 runt_out", 32'(rt64), 32'(e.runt));
            end
        end
    end

    initial begin
        bq_t  f, g;
        exp_t good;
        int   db8, db64, kind, ab;
        bit   gp;

        good = '{ok: 1'b1, runt: 1'b0, crc: RESIDUE};
        f = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
             8'h26, 8'h39, 8'hF4, 8'hCB};

        repeat (3) cyc();
        check("dut8 reset done_out", 32'(dn8), 32'd0);
        check("dut8 reset crc_ok_out", 32'(ok8), 32'd0);
        check("dut8 reset runt_out", 32'(rt8), 32'd0);
        check("dut8 reset crc_out", c8, 32'hFFFFFFFF);
        check("dut8 reset busy_out", 32'(bz8), 32'd0);
        check("dut64 reset done_out", 32'(dn64), 32'd0);
        check("dut64 reset crc_out", c64, 32'hFFFFFFFF);
        check("dut64 reset busy_out", 32'(bz64), 32'd0);
        reset = 1'b0;

        // Known-answer frame and a corrupted copy
        expect8(good); send8(f, -1, 0); idle(2);
        check("dut8 busy_out after frame", 32'(bz8), 32'd0);
        g = f; g[4] = 8'h36;
        expect8(model(g)); send8(g, -1, 0); idle(2);

        // 64-bit partial last beat: 5 valid bytes, then 6 with junk
        expect64(good); send64(f, -1, 0); idle(2);
        g = f; g.push_back(8'h5A);
        expect64(model(g)); send64(g, -1, 0); idle(2);

        // Runts
        g = {8'h00};
        expect8(model(g)); send8(g, -1, 0); idle(2);
        g = {8'h11, 8'h22, 8'h33};
        expect64(model(g)); send64(g, -1, 0); idle(2);

        // Back-to-back: good, aborted on last beat, good
        db8 = dones8; db64 = dones64;
        expect8(good); send8(f, -1, 0); send8(f, f.size() - 1, 0);
        expect8(good); send8(f, -1, 0); idle(3);
        check("dut8 back-to-back done count", 32'(dones8 - db8), 32'd2);
        expect64(good); send64(f, -1, 0); send64(f, 1, 0);
        expect64(good); send64(f, -1, 0); idle(3);
        check("dut64 back-to-back done count", 32'(dones64 - db64), 32'd2);
        check_stats();

        // Reset mid-frame
        for (int i = 0; i < 5; i++) begin
            cyc(); v8 = 1'b1; d8 = f[i]; l8 = 1'b0; a8 = 1'b0;
        end
        cyc(); v8 = 1'b0; reset = 1'b1;
        cyc();
        check("dut8 busy_out after reset", 32'(bz8), 32'd0);
        check("dut8 crc_out after reset", c8, 32'hFFFFFFFF);
        check("dut64 crc_out after reset", c64, 32'hFFFFFFFF);
        reset = 1'b0;
        eg8 = 0; eb8 = 0; ea8 = 0; eg64 = 0; eb64 = 0; ea64 = 0;
        db8 = dones8;
        idle(1);
        check("dut8 no done after reset", 32'(dones8 - db8), 32'd0);
        expect8(good); send8(f, -1, 0); idle(2);

        // Random mix: good, corrupted, runt, aborted, with and without gaps
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            f = gen_frame(kind);
            gp = 1'($urandom_range(0, 1));
            if (kind == 8) send8(f, $urandom_range(0, f.size() - 1), gp);
            else begin expect8(model(f)); send8(f, -1, gp); end
            idle($urandom_range(0, 2));
            kind = $urandom_range(0, 9);
            f = gen_frame(kind);
            gp = 1'($urandom_range(0, 1));
            if (kind == 8) begin
                ab = $urandom_range(0, (f.size() + 7) / 8 - 1);
                send64(f, ab, gp);
            end else begin
                expect64(model(f)); send64(f, -1, gp);
            end
            idle($urandom_range(0, 2));
        end

        idle(5);
        check("dut8 scoreboard drained", 32'(q8.size()), 32'd0);
        check("dut64 scoreboard drained", 32'(q64.size()), 32'd0);
        check_stats();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
